// File: rtl/move_input_ctrl_if.sv
// Command handshake between the button front end (master) and the piece mover (slave).
// One-hot left/right/rotate qualified by cmd_valid; cmd_ack pops the presented command.
interface move_input_ctrl_if;
    logic cmd_valid;
    logic cmd_ack;
    logic left;
    logic right;
    logic rotate;

    modport master (
        output cmd_valid,
        output left,
        output right,
        output rotate,
        input  cmd_ack
    );

    modport slave (
        input  cmd_valid,
        input  left,
        input  right,
        input  rotate,
        output cmd_ack
    );
endinterface

// File: rtl/move_input_ctrl.sv
// Button front end: sync + debounce + press detect per button, priority enqueue into a small command FIFO.
// Latency raw edge -> cmd_valid is DEBOUNCE_CYCLES+4 cycles; full FIFO holds presses pending, a repeat press while pending sets overflow.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clka,
    input  logic                reset,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_rotate,
    input  logic [2:0]          game_state,
    move_input_ctrl_if.master   cmd,
    output logic [2:0]          fifo_count,
    output logic                overflow
);

    localparam int DW = 4;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] ST_MOVE     = 3'b001;
    localparam logic [2:0] ST_NEWBOARD = 3'b100;

    localparam logic [1:0] CODE_LEFT   = 2'b01;
    localparam logic [1:0] CODE_RIGHT  = 2'b10;
    localparam logic [1:0] CODE_ROTATE = 2'b11;

    // Bit 0 = left, 1 = right, 2 = rotate throughout.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    press;

    logic [2:0]    pending;
    logic [2:0]    enq_clr;
    logic [1:0]    enq_code;
    logic          push;
    logic          pop;
    logic          newboard;
    logic          in_move;
    logic          lost;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [1:0]    head;

    assign raw = {btn_rotate, btn_right, btn_left};

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    // This cycle is the DEBOUNCE_CYCLES-th consecutive mismatch.
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable & ~stable_d;

    assign newboard = (game_state == ST_NEWBOARD);
    assign in_move  = (game_state == ST_MOVE);
    assign head     = mem[rd_ptr];

    always_comb begin
        cmd.cmd_valid = (cnt != '0) && in_move;
        cmd.left      = cmd.cmd_valid && (head == CODE_LEFT);
        cmd.right     = cmd.cmd_valid && (head == CODE_RIGHT);
        cmd.rotate    = cmd.cmd_valid && (head == CODE_ROTATE);
    end

    assign pop = cmd.cmd_valid && cmd.cmd_ack;

    always_comb begin
        enq_clr  = 3'b000;
        enq_code = CODE_LEFT;
        push     = 1'b0;
        if (!newboard && (pending != 3'b000) &&
            ((cnt < CW'(FIFO_DEPTH)) || pop)) begin
            push = 1'b1;
            if (pending[0]) begin
                enq_clr  = 3'b001;
                enq_code = CODE_LEFT;
            end else if (pending[1]) begin
                enq_clr  = 3'b010;
                enq_code = CODE_RIGHT;
            end else begin
                enq_clr  = 3'b100;
                enq_code = CODE_ROTATE;
            end
        end
    end

    // A press only counts as lost if its pending bit survives this cycle.
    assign lost = |(press & pending & ~enq_clr);

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (newboard) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~enq_clr) | press;
            if (lost) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (newboard) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enq_code;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // An 8-deep queue reports a full count as 7 on the 3-bit output.
    if (CW > 3) begin : g_count_sat
        assign fifo_count = (cnt > CW'(7)) ? 3'd7 : cnt[2:0];
    end else begin : g_count_direct
        assign fifo_count = 3'(cnt);
    end

`ifndef SYNTHESIS
    a_onehot : assert property (@(posedge clka) disable iff (reset)
        cmd.cmd_valid |-> $onehot({cmd.left, cmd.right, cmd.rotate}));
    a_count_range : assert property (@(posedge clka) disable iff (reset)
        cnt <= CW'(FIFO_DEPTH));
    a_no_pop_empty : assert property (@(posedge clka) disable iff (reset)
        pop |-> (cnt != '0));
`endif

endmodule
